// File: rtl/scan_out_deser.sv
// scan_out_deser: samples a qualified serial readback line, packs bits LSB-first into words, buffers them in a small FIFO.
// Latency: a word is written to the FIFO on the edge that samples its last bit; done_o follows one cycle after that edge.
// Backpressure: readout pops via valid/ready; the serial stream cannot stall, so a push into a full FIFO drops the word and sets overflow_o.

// scan_out_fifo: generic synchronous FIFO with a registered-pointer head and an occupancy counter.
// Latency: a written entry is visible at the head on the cycle after the write edge.
// Backpressure: in_rdy is low only when full and no pop is happening in the same cycle.
module scan_out_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         pl_clk1,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    // Handshake decode; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        out_vld = (count != '0);
        rd_en   = out_vld && out_rdy;
        in_rdy  = (count != CW'(DEPTH)) || rd_en;
        wr_en   = in_vld && in_rdy;
        out_dat = out_vld ? mem[rd_ptr] : '0;
    end

    // Storage array; contents need no reset because the head is gated by out_vld.
    always_ff @(posedge pl_clk1) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge pl_clk1) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module scan_out_deser #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              pl_clk1,
    input  logic              reset,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  bit_count_i,
    input  logic              sample_en_i,
    input  logic              serial_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);
    localparam int FILL_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  rem_q;
    logic [FILL_W-1:0] fill_q;
    logic [WORD_W-1:0] shift_q;
    logic              overflow_q;

    logic              sample;
    logic              last_bit;
    logic              word_end;
    logic              drop;
    logic [WORD_W-1:0] bit_vec;
    logic [WORD_W-1:0] merged;
    logic              fifo_in_rdy;
    logic [WORD_W:0]   head_dat;

    // Sample qualification and the word being assembled including this cycle's bit.
    always_comb begin
        sample   = (state_q == ST_CAPTURE) && sample_en_i && (rem_q != '0);
        last_bit = sample && (rem_q == CNT_W'(1));
        word_end = sample && ((fill_q == FILL_W'(WORD_W - 1)) || last_bit);
        bit_vec  = {{(WORD_W-1){1'b0}}, serial_i};
        merged   = shift_q | (bit_vec << fill_q);
        drop     = word_end && !fifo_in_rdy;
    end

    // State register.
    always_ff @(posedge pl_clk1) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: FLUSH adds the cycle between the final push and the done pulse.
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                busy_o = 1'b1;
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                end else if (last_bit) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture datapath: latch the request on start, then shift bits in and clear after each push.
    always_ff @(posedge pl_clk1) begin
        if (reset) begin
            rem_q      <= '0;
            fill_q     <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start_i) begin
                rem_q      <= bit_count_i;
                fill_q     <= '0;
                shift_q    <= '0;
                overflow_q <= 1'b0;
            end else if (sample) begin
                rem_q <= rem_q - CNT_W'(1);
                if (word_end) begin
                    fill_q  <= '0;
                    shift_q <= '0;
                end else begin
                    fill_q  <= fill_q + FILL_W'(1);
                    shift_q <= merged;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    scan_out_fifo #(
        .W     (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pl_clk1 (pl_clk1),
        .reset   (reset),
        .in_vld  (word_end),
        .in_dat  ({last_bit, merged}),
        .in_rdy  (fifo_in_rdy),
        .out_vld (word_valid_o),
        .out_dat (head_dat),
        .out_rdy (word_ready_i)
    );

    // Head entry carries the last flag in its top bit.
    always_comb begin
        word_o     = head_dat[WORD_W-1:0];
        last_o     = head_dat[WORD_W];
        overflow_o = overflow_q;
    end
endmodule
